// File: rtl/bot_batch_distributor_pkg.sv
// Shared pipeline globals for the bot batch distributor: lane count,
// bot/permute widths and the distributor FSM state encoding.
package bot_batch_distributor_pkg;

  localparam int NUMBER_OF_PERMUTATORS = 4;
  localparam int BOT_W                 = 128;
  localparam int PERM_W                = 6;
  localparam int ISSUED_W              = 32;

  typedef logic [BOT_W-1:0]  bot_t;
  typedef logic [PERM_W-1:0] perm_t;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/bot_batch_distributor_if.sv
// Bot stream interface: upstream bot handshake, per-lane permutator outputs,
// per-lane slowdown requests and the batch counter.
interface bot_batch_distributor_if
  import bot_batch_distributor_pkg::*;
#(
  parameter int NUM_LANES = NUMBER_OF_PERMUTATORS
);

  bot_t                         bot_in;
  perm_t                        bot_in_permutes;
  logic                         bot_in_valid;
  logic                         bot_in_last;
  logic                         bot_in_ready;
  logic [BOT_W*NUM_LANES-1:0]   bots_out;
  logic [PERM_W*NUM_LANES-1:0]  valid_bots_permutes;
  logic [NUM_LANES-1:0]         batches_done;
  logic [NUM_LANES-1:0]         slow_down_inputs;
  logic [ISSUED_W-1:0]          batches_issued;

  // Distributor side.
  modport slave (
    input  bot_in, bot_in_permutes, bot_in_valid, bot_in_last, slow_down_inputs,
    output bot_in_ready, bots_out, valid_bots_permutes, batches_done, batches_issued
  );

  // Upstream source / pipeline side.
  modport master (
    output bot_in, bot_in_permutes, bot_in_valid, bot_in_last, slow_down_inputs,
    input  bot_in_ready, bots_out, valid_bots_permutes, batches_done, batches_issued
  );

endinterface

// File: rtl/bot_batch_distributor_rr_lane_picker.sv
// Round-robin lane search: starting one past the previous lane, return the
// first lane whose request bit is set.
module rr_lane_picker #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2
) (
  input  logic [NUM_LANES-1:0] i_req,
  input  logic [LANE_W-1:0]    i_prev,
  output logic [LANE_W-1:0]    o_next,
  output logic                 o_found
);

  // Scan from farthest to nearest so the nearest requesting lane wins.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    o_next  = i_prev;
    o_found = 1'b0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      if (i_req[(int'(i_prev) + k) % NUM_LANES]) begin
        o_found = 1'b1;
        o_next  = LANE_W'((int'(i_prev) + k) % NUM_LANES);
      end
    end
  end

endmodule

// File: rtl/bot_batch_distributor.sv
// Bot batch distributor: assigns whole batches of bots round-robin to
// permutator lanes, honouring per-lane slowdown, with registered outputs.
module bot_batch_distributor
  import bot_batch_distributor_pkg::*;
#(
  parameter int NUM_LANES      = NUMBER_OF_PERMUTATORS,
  parameter int SLOWDOWN_SLACK = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  bot_batch_distributor_if.slave    io_bus
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  // One register stage on slowdown gives one cycle of slack; less than that is unachievable.
  if (SLOWDOWN_SLACK < 1) begin : g_slack_check
    $error("SLOWDOWN_SLACK must be at least 1");
  end

  state_e                      r_state;
  logic [LANE_W-1:0]           r_lane;
  logic [NUM_LANES-1:0]        r_slow_down;
  logic [BOT_W*NUM_LANES-1:0]  r_bots_out;
  logic [PERM_W*NUM_LANES-1:0] r_valid_perm;
  logic [NUM_LANES-1:0]        r_batches_done;
  logic [ISSUED_W-1:0]         r_batches_issued;

  logic [LANE_W-1:0]           w_next_lane;
  logic                        w_found;
  logic                        w_ready;
  logic                        w_accept;

  rr_lane_picker #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_picker (
    .i_req   (~r_slow_down),
    .i_prev  (r_lane),
    .o_next  (w_next_lane),
    .o_found (w_found)
  );

  // Only streaming to a lane that is not currently slowed accepts beats.
  assign w_ready  = (r_state == STREAM) && !r_slow_down[r_lane] && !rst;
  assign w_accept = w_ready && io_bus.bot_in_valid;

  // Register slowdown requests once before any decision uses them.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) r_slow_down <= '0;
    else     r_slow_down <= io_bus.slow_down_inputs;
  end

  // Batch FSM: pick a lane, stream the batch to it, then pulse batch-done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= SELECT;
      r_lane           <= LANE_W'(NUM_LANES - 1);
      r_valid_perm     <= '0;
      r_batches_done   <= '0;
      r_batches_issued <= '0;
    end else begin
      r_valid_perm   <= '0;
      r_batches_done <= '0;
      case (r_state)
        SELECT: begin
          if (w_found) begin
            r_lane  <= w_next_lane;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_accept) begin
            r_valid_perm[PERM_W*int'(r_lane) +: PERM_W] <= io_bus.bot_in_permutes;
            if (io_bus.bot_in_last) r_state <= DONE;
          end
        end
        DONE: begin
          r_batches_done[r_lane] <= 1'b1;
          r_batches_issued       <= r_batches_issued + 1'b1;
          r_state                <= SELECT;
        end
        default: r_state <= SELECT;
      endcase
    end
  end

  // Capture the accepted bot on the current lane; meaningful only where the mask is non-zero.
  always_ff @(posedge clk) begin
    // NOTE: bot data is qualified by the permute mask, so it needs no reset.
    if (w_accept) r_bots_out[BOT_W*int'(r_lane) +: BOT_W] <= io_bus.bot_in;
  end

  assign io_bus.bot_in_ready        = w_ready;
  assign io_bus.bots_out            = r_bots_out;
  assign io_bus.valid_bots_permutes = r_valid_perm;
  assign io_bus.batches_done        = r_batches_done;
  assign io_bus.batches_issued      = r_batches_issued;

endmodule
